// File: rtl/param_code_detonator.sv
// Parametrised numeric-code detonator controller: edge-detected keypad capture,
// changeable BCD code, retry lockout and entry timeout in one synchronous FSM.
module param_code_detonator #(
  parameter int                  DIGITS      = 4,
  parameter logic [4*DIGITS-1:0] CODE_INIT   = 16'h2580,
  parameter int                  MAX_TRIES   = 3,
  parameter int                  BLINK_MAX   = 25_000_000,
  parameter int                  TIMEOUT_MAX = 250_000_000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wait_t,
  input  logic                             setup,
  input  logic                             ready,
  input  logic                             fire,
  input  logic                             sure,
  input  logic                             change,
  input  logic [9:0]                       key,
  output logic                             lt,
  output logic                             bt,
  output logic                             rt,
  output logic                             lb,
  output logic                             locked,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic [6:0]                       m_disp
);

  localparam int EW  = 4 * DIGITS;
  localparam int CW  = $clog2(DIGITS + 1);
  localparam int TW  = $clog2(MAX_TRIES + 1);
  localparam int BW  = $clog2(BLINK_MAX + 1);
  localparam int TOW = $clog2(TIMEOUT_MAX + 1);

  localparam logic [CW-1:0]  CNT_FULL   = CW'(DIGITS);
  localparam logic [TW-1:0]  TRIES_INIT = TW'(MAX_TRIES);
  localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_MAX);
  localparam logic [TOW-1:0] TMO_LAST   = TOW'(TIMEOUT_MAX);

  typedef enum logic [2:0] {
    S_WAIT, S_READY, S_CHECK, S_OK, S_FIRE, S_ERROR, S_LOCK, S_NEWCODE
  } state_t;

  state_t         state;
  logic [EW-1:0]  code;
  logic [EW-1:0]  entry;
  logic [CW-1:0]  cnt;
  logic [9:0]     key_q;
  logic [9:0]     press;
  logic           key_ok;
  logic [3:0]     digit;
  logic [6:0]     seg;
  logic [TOW-1:0] tmo_cnt;
  logic [BW-1:0]  blink_cnt;
  logic           blink_q;
  logic           match;

  // A press counts only when exactly one new key edge appears this cycle.
  assign press  = key & ~key_q;
  assign key_ok = (press != '0) && ((press & (press - 10'd1)) == '0);

  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < 10; i++)
      if (press[i]) digit = 4'(i);
  end

  always_comb begin
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  end

  assign lt     = (state == S_OK);
  assign bt     = (state == S_FIRE);
  assign locked = (state == S_LOCK);
  assign lb     = (state == S_ERROR) || locked;
  assign rt     = blink_q | locked;

  // Entry, timeout and blink registers default to cleared; only paths that
  // stay in an entry state or in ERROR carry them forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_WAIT;
      code       <= CODE_INIT;
      tries_left <= TRIES_INIT;
      cnt        <= '0;
      entry      <= '0;
      key_q      <= '0;
      tmo_cnt    <= '0;
      blink_cnt  <= '0;
      blink_q    <= 1'b0;
      match      <= 1'b0;
      m_disp     <= 7'b1111111;
    end else begin
      key_q     <= key;
      cnt       <= '0;
      entry     <= '0;
      m_disp    <= 7'b1111111;
      tmo_cnt   <= '0;
      blink_cnt <= '0;
      blink_q   <= 1'b0;
      case (state)
        S_WAIT:
          if (fire)       state <= S_ERROR;
          else if (ready) state <= S_READY;
        S_READY, S_NEWCODE: begin
          if (fire)        state <= S_ERROR;
          else if (wait_t) state <= S_WAIT;
          else if (key_ok && cnt != CNT_FULL) begin
            cnt    <= cnt + 1'b1;
            entry  <= EW'({entry, digit});
            m_disp <= seg;
          end
          else if (key_ok) state <= S_ERROR;
          else if (sure && cnt == CNT_FULL) begin
            // entry is cleared on leaving, so the comparison is latched for CHECK
            if (state == S_READY) begin
              match <= (entry == code);
              state <= S_CHECK;
            end else begin
              code  <= entry;
              state <= S_WAIT;
            end
          end
          else if (sure)                 state <= S_ERROR;
          else if (tmo_cnt == TMO_LAST)  state <= S_WAIT;
          else begin
            cnt     <= cnt;
            entry   <= entry;
            m_disp  <= m_disp;
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_CHECK:
          if (match) begin
            state      <= S_OK;
            tries_left <= TRIES_INIT;
          end else if (tries_left == TW'(1)) begin
            state      <= S_LOCK;
            tries_left <= '0;
          end else begin
            state      <= S_ERROR;
            tries_left <= tries_left - 1'b1;
          end
        S_OK:
          if (fire)        state <= S_FIRE;
          else if (wait_t) state <= S_WAIT;
          else if (change) state <= S_NEWCODE;
        S_FIRE: state <= S_WAIT;
        S_ERROR:
          if (setup) state <= S_WAIT;
          else if (blink_cnt == BLINK_LAST) blink_q <= ~blink_q;
          else begin
            blink_cnt <= blink_cnt + 1'b1;
            blink_q   <= blink_q;
          end
        S_LOCK: ;
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule
